sram_rw_ctrl: RTL and testbench

Synchronous controller that turns a single-beat valid/ready request stream into asynchronous SRAM pin cycles (ce_n, oe_n, we_n, addr, bidirectional data). It sits directly upstream of the external 10 ns async SRAM, or of its behavioural model in benches. It runs at 100 MHz, meets tAA 9 ns, tDOE 6 ns and tAW 8 ns, and registers every SRAM control pin so the pins cannot glitch.

---
 rtl/sram_rw_ctrl_pkg.sv | 35 +++
 rtl/sram_data_iobuf.sv | 26 ++
 rtl/sram_rw_ctrl.sv | 143 ++++++++++++++
 tb/tb_sram_rw_ctrl.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_rw_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : sram_rw_ctrl_pkg                                           |
// | Description : Shared definitions for the async SRAM read/write           |
// |               controller. Holds the FSM state encoding, the default      |
// |               pin-timing cycle counts and the wait-counter width helper. |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package sram_rw_ctrl_pkg;

  // Encoding is fixed so that state values seen in waveforms or debug
  // taps stay stable across builds.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD       = 3'd1,
    ST_WR_SETUP = 3'd2,
    ST_WR_PULSE = 3'd3,
    ST_WR_HOLD  = 3'd4
  } state_t;

  // At 100 MHz, two cycles of ce_n/oe_n low covers tAA (9 ns) and tDOE
  // (6 ns) plus pad and board delay. One cycle of we_n low covers tAW (8 ns).
  localparam int DEF_READ_CYCLES = 2;
  localparam int DEF_WE_CYCLES   = 1;

  // The wait counter is loaded with (cycles - 1), so it needs to hold
  // values up to max(READ_CYCLES, WE_CYCLES) - 1. It is at least 1 bit wide.
  function automatic int cnt_width(input int rd_cycles, input int we_cycles);
    int max_cycles;
    max_cycles = (rd_cycles > we_cycles) ? rd_cycles : we_cycles;
    return (max_cycles <= 2) ? 1 : $clog2(max_cycles);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sram_data_iobuf.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : sram_data_iobuf                                            |
// | Description : Tri-state pad buffer for the SRAM data bus. In             |
// |               simulation this is a generic conditional assign. On iCE40  |
// |               this body is replaced by a bank of SB_IO primitives.       |
// | Ports       : out_en   - drive pad when high, release (Z) when low        |
// |               out_data - value driven onto the pad                       |
// |               in_data  - value currently on the pad                      |
// |               pad      - bidirectional SRAM data pins                    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module sram_data_iobuf #(
  parameter int DATA_BITS = 8
) (
  input  logic                 out_en,
  input  logic [DATA_BITS-1:0] out_data,
  output logic [DATA_BITS-1:0] in_data,
  inout  wire  [DATA_BITS-1:0] pad
);

  assign pad     = out_en ? out_data : {DATA_BITS{1'bz}};
  assign in_data = pad;

endmodule
`default_nettype wire

// File: rtl/sram_rw_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : sram_rw_ctrl                                               |
// | Description : Converts a single-beat valid/ready request stream into     |
// |               async SRAM pin cycles. Every SRAM control pin comes from   |
// |               a flop, so the pins cannot glitch.                         |
// | Ports       : clk, reset          - clock / async active-high reset      |
// |               req_valid/req_ready - request handshake                    |
// |               req_write/addr/wdata- request fields (1 = write)           |
// |               resp_valid/rdata    - read completion pulse and data       |
// |               sram_ce_n/oe_n/we_n - active-low SRAM controls             |
// |               sram_addr/sram_data - SRAM address and bidirectional data  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module sram_rw_ctrl
  import sram_rw_ctrl_pkg::*;
#(
  parameter int ADDR_BITS   = 10,
  parameter int DATA_BITS   = 8,
  parameter int READ_CYCLES = DEF_READ_CYCLES,  // must be >= 1
  parameter int WE_CYCLES   = DEF_WE_CYCLES     // must be >= 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [ADDR_BITS-1:0] req_addr,
  input  logic [DATA_BITS-1:0] req_wdata,
  output logic                 resp_valid,
  output logic [DATA_BITS-1:0] resp_rdata,
  output logic                 sram_ce_n,
  output logic                 sram_oe_n,
  output logic                 sram_we_n,
  output logic [ADDR_BITS-1:0] sram_addr,
  inout  wire  [DATA_BITS-1:0] sram_data
);

  localparam int                 c_CNT_W   = cnt_width(READ_CYCLES, WE_CYCLES);
  localparam logic [c_CNT_W-1:0] c_RD_LOAD = c_CNT_W'(READ_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_WE_LOAD = c_CNT_W'(WE_CYCLES - 1);

  state_t               r_state;
  logic [c_CNT_W-1:0]   r_cnt;
  logic [DATA_BITS-1:0] r_wdata;
  logic                 r_drive;
  logic [DATA_BITS-1:0] w_rdata;
  logic                 w_accept;

  // Ready depends only on state and reset. It has no path from req_valid,
  // so upstream logic can safely make valid depend on ready.
  assign req_ready = (r_state == ST_IDLE) && !reset;
  assign w_accept  = req_valid && req_ready;

  sram_data_iobuf #(
    .DATA_BITS (DATA_BITS)
  ) u_iobuf (
    .out_en   (r_drive),
    .out_data (r_wdata),
    .in_data  (w_rdata),
    .pad      (sram_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_wdata    <= '0;
      r_drive    <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      sram_ce_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
      sram_we_n  <= 1'b1;
      sram_addr  <= '0;
    end else begin
      resp_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // sram_addr is loaded only here, so it stays stable for the
          // whole operation, including the write hold cycle.
          if (w_accept) begin
            sram_addr <= req_addr;
            sram_ce_n <= 1'b0;
            if (req_write) begin
              r_wdata <= req_wdata;
              r_drive <= 1'b1;
              r_state <= ST_WR_SETUP;
            end else begin
              sram_oe_n <= 1'b0;
              r_cnt     <= c_RD_LOAD;
              r_state   <= ST_RD;
            end
          end
        end

        ST_RD: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            resp_rdata <= w_rdata;
            resp_valid <= 1'b1;
            sram_ce_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
            r_state    <= ST_IDLE;
          end
        end

        // One cycle with the address and data already driven before we_n
        // falls. This gives address setup to the write strobe.
        ST_WR_SETUP: begin
          sram_we_n <= 1'b0;
          r_cnt     <= c_WE_LOAD;
          r_state   <= ST_WR_PULSE;
        end

        ST_WR_PULSE: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            sram_we_n <= 1'b1;
            r_state   <= ST_WR_HOLD;
          end
        end

        // Address, data and ce_n are held for one cycle after we_n rises.
        // This is the SRAM data hold time. ce_n then rises in the
        // following IDLE cycle, which also gives the bus turnaround.
        ST_WR_HOLD: begin
          sram_ce_n <= 1'b1;
          r_drive   <= 1'b0;
          r_state   <= ST_IDLE;
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sram_rw_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_sram_rw_ctrl                                            |
// | Description : Self-checking bench for sram_rw_ctrl. Instance 0 uses the  |
// |               default timing and instance 1 uses READ_CYCLES=3 and       |
// |               WE_CYCLES=2. Each instance has its own async SRAM model.   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_sram_rw_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid  [2];
  logic       req_ready  [2];
  logic       req_write  [2];
  logic [9:0] req_addr   [2];
  logic [7:0] req_wdata  [2];
  logic       resp_valid [2];
  logic [7:0] resp_rdata [2];
  logic       ce_n       [2];
  logic       oe_n       [2];
  logic       we_n       [2];
  logic [9:0] addr       [2];
  wire  [7:0] sram_data0;
  wire  [7:0] sram_data1;

  logic [7:0] mem0 [1024];
  logic [7:0] mem1 [1024];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sram_rw_ctrl #(.ADDR_BITS(10), .DATA_BITS(8), .READ_CYCLES(2), .WE_CYCLES(1)) u_dut0 (
    .clk(clk), .reset(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]),
    .sram_ce_n(ce_n[0]), .sram_oe_n(oe_n[0]), .sram_we_n(we_n[0]),
    .sram_addr(addr[0]), .sram_data(sram_data0)
  );

  sram_rw_ctrl #(.ADDR_BITS(10), .DATA_BITS(8), .READ_CYCLES(3), .WE_CYCLES(2)) u_dut1 (
    .clk(clk), .reset(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]),
    .sram_ce_n(ce_n[1]), .sram_oe_n(oe_n[1]), .sram_we_n(we_n[1]),
    .sram_addr(addr[1]), .sram_data(sram_data1)
  );

  // Async SRAM models: drive the bus on a read (ce and oe low, we high) and
  // latch the bus on the rising edge of we_n while the chip is selected.
  assign sram_data0 = (!ce_n[0] && !oe_n[0] && we_n[0]) ? mem0[addr[0]] : 8'bz;
  assign sram_data1 = (!ce_n[1] && !oe_n[1] && we_n[1]) ? mem1[addr[1]] : 8'bz;
  always @(posedge we_n[0]) if (!ce_n[0]) mem0[addr[0]] = sram_data0;
  always @(posedge we_n[1]) if (!ce_n[1]) mem1[addr[1]] = sram_data1;

  // Pin monitors, sampled on the falling edge.
  int   ovl_viol = 0;
  bit   b2b_on   = 1'b0;
  bit   seen_low = 1'b0;
  bit   prev_low = 1'b0;
  int   hi_run   = 0;
  int   gap_err  = 0;
  int   n_gaps   = 0;

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++)
      if (!oe_n[d] && !we_n[d]) ovl_viol <= ovl_viol + 1;
    if (b2b_on) begin
      if (!ce_n[0]) begin
        if (!prev_low && seen_low) begin
          n_gaps <= n_gaps + 1;
          if (hi_run != 1) gap_err <= gap_err + 1;
        end
        seen_low <= 1'b1;
        prev_low <= 1'b1;
        hi_run   <= 0;
      end else begin
        prev_low <= 1'b0;
        hi_run   <= hi_run + 1;
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue one request on instance d and follow it until the controller is
  // back in IDLE, plus one extra cycle to see that resp_valid falls again.
  task automatic do_op(input int d, input bit wr, input logic [9:0] a, input logic [7:0] wd,
                       output logic [7:0] rd, output int lat, output int busy,
                       output int we_low, output int oe_bad, output int stuck);
    int guard;
    int cyc;
    rd = '0; lat = 0; busy = 0; we_low = 0; oe_bad = 0; stuck = 0;
    req_valid[d] = 1'b1; req_write[d] = wr; req_addr[d] = a; req_wdata[d] = wd;
    guard = 0;
    while (!req_ready[d] && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    if (guard >= 50) check("accept_timeout", 0, 1);
    @(posedge clk); #1;
    req_valid[d] = 1'b0; req_write[d] = 1'b0;
    cyc = 1; guard = 0;
    while (!req_ready[d] && guard < 50) begin
      busy++;
      if (!we_n[d]) we_low++;
      if (wr && !oe_n[d]) oe_bad++;
      if (resp_valid[d] && lat == 0) begin lat = cyc; rd = resp_rdata[d]; end
      @(posedge clk); #1; cyc++; guard++;
    end
    if (guard >= 50) check("op_timeout", 0, 1);
    if (resp_valid[d] && lat == 0) begin lat = cyc; rd = resp_rdata[d]; end
    @(posedge clk); #1;
    stuck = int'(resp_valid[d]);
  endtask

  task automatic set_b2b(input int idx);
    req_write[0] = (idx < 1024);
    req_addr[0]  = 10'(idx % 1024);
    req_wdata[0] = 8'(idx % 256);
  endtask

  typedef struct {
    bit         wr;
    logic [9:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [12];

  initial begin
    logic [7:0] rd;
    int lat, busy, we_low, oe_bad, stuck, pulses, guard, idx, rd_err, n_rd;
    bit acc, acc_wr, last_wr;
    logic [9:0] acc_a, qa;
    logic [9:0] aq [$];

    vecs[0]  = '{1'b1, 10'h005, 8'hA5, 8'h00};
    vecs[1]  = '{1'b0, 10'h005, 8'h00, 8'hA5};
    vecs[2]  = '{1'b1, 10'h3FF, 8'hFF, 8'h00};
    vecs[3]  = '{1'b1, 10'h000, 8'h00, 8'h00};
    vecs[4]  = '{1'b0, 10'h3FF, 8'h00, 8'hFF};
    vecs[5]  = '{1'b0, 10'h000, 8'h00, 8'h00};
    vecs[6]  = '{1'b1, 10'h1FF, 8'h5A, 8'h00};
    vecs[7]  = '{1'b1, 10'h200, 8'hC3, 8'h00};
    vecs[8]  = '{1'b0, 10'h1FF, 8'h00, 8'h5A};
    vecs[9]  = '{1'b0, 10'h000, 8'h00, 8'h00};
    vecs[10] = '{1'b0, 10'h200, 8'h00, 8'hC3};
    vecs[11] = '{1'b0, 10'h3FF, 8'h00, 8'hFF};

    for (int i = 0; i < 1024; i++) begin mem0[i] = 8'h00; mem1[i] = 8'h00; end
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0; req_write[d] = 1'b0; req_addr[d] = '0; req_wdata[d] = '0;
    end

    // Reset state.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ce_n", int'(ce_n[0]), 1);
    check("rst_oe_n", int'(oe_n[0]), 1);
    check("rst_we_n", int'(we_n[0]), 1);
    check("rst_addr", int'(addr[0]), 0);
    check("rst_resp_valid", int'(resp_valid[0]), 0);
    check("rst_resp_rdata", int'(resp_rdata[0]), 0);
    check("rst_ready_low", int'(req_ready[0]), 0);
    rst = 1'b0;
    #1;
    check("rel_ready", int'(req_ready[0]), 1);
    check("rel_ready_1", int'(req_ready[1]), 1);

    // Directed table on the default-timing instance.
    for (int i = 0; i < 12; i++) begin
      do_op(0, vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, lat, busy, we_low, oe_bad, stuck);
      if (vecs[i].wr) begin
        check($sformatf("v%0d_we_low_cycles", i), we_low, 1);
        check($sformatf("v%0d_wr_busy", i), busy, 3);
        check($sformatf("v%0d_wr_oe_n", i), oe_bad, 0);
        check($sformatf("v%0d_wr_no_resp", i), lat, 0);
      end else begin
        check($sformatf("v%0d_rdata", i), int'(rd), int'(vecs[i].exp));
        check($sformatf("v%0d_rd_latency", i), lat, 3);
        check($sformatf("v%0d_rd_busy", i), busy, 2);
        check($sformatf("v%0d_rd_we_n", i), we_low, 0);
      end
      check($sformatf("v%0d_resp_one_cycle", i), stuck, 0);
    end

    // Back-to-back traffic with req_valid held high: write every address,
    // then read every address back.
    b2b_on = 1'b1;
    idx = 0; guard = 0; rd_err = 0; n_rd = 0; last_wr = 1'b0;
    set_b2b(0);
    req_valid[0] = 1'b1;
    while ((idx < 2048 || aq.size() > 0) && guard < 20000) begin
      acc    = req_valid[0] && req_ready[0];
      acc_wr = req_write[0];
      acc_a  = req_addr[0];
      @(posedge clk); #1; guard++;
      if (acc) begin
        if (!acc_wr) aq.push_back(acc_a);
        last_wr = acc_wr;
        idx++;
        if (idx < 2048) set_b2b(idx); else req_valid[0] = 1'b0;
      end
      if (last_wr && !req_ready[0] && !oe_n[0]) ovl_viol++;
      if (resp_valid[0]) begin
        n_rd++;
        if (aq.size() == 0) rd_err++;
        else begin
          qa = aq.pop_front();
          if (resp_rdata[0] != qa[7:0]) rd_err++;
        end
      end
    end
    @(negedge clk);
    b2b_on = 1'b0;
    req_valid[0] = 1'b0;
    check("b2b_timeout", int'(guard < 20000), 1);
    check("b2b_read_errors", rd_err, 0);
    check("b2b_read_count", n_rd, 1024);
    check("b2b_gap_not_one_cycle", gap_err, 0);
    check("b2b_gap_count", n_gaps, 2047);
    @(posedge clk); #1;

    // Reset during WR_PULSE: address 0x077 holds 0x77 from the sweep.
    req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 10'h077; req_wdata[0] = 8'h99;
    @(posedge clk); #1;
    req_valid[0] = 1'b0; req_write[0] = 1'b0;
    check("mwr_setup_we_n", int'(we_n[0]), 1);
    @(posedge clk); #1;
    check("mwr_pulse_we_n", int'(we_n[0]), 0);
    #2 rst = 1'b1;
    #1;
    check("mwr_async_we_n", int'(we_n[0]), 1);
    check("mwr_async_ce_n", int'(ce_n[0]), 1);
    pulses = 0;
    repeat (3) begin @(posedge clk); #1; if (resp_valid[0]) pulses++; end
    rst = 1'b0;
    check("mwr_resp_during_reset", pulses, 0);
    do_op(0, 1'b0, 10'h077, 8'h00, rd, lat, busy, we_low, oe_bad, stuck);
    check("mwr_old_or_new", int'(rd == 8'h77 || rd == 8'h99), 1);
    check("mwr_read_latency", lat, 3);

    // Reset during a read: the read is dropped and no response appears.
    req_valid[0] = 1'b1; req_write[0] = 1'b0; req_addr[0] = 10'h010;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    check("mrd_oe_n_low", int'(oe_n[0]), 0);
    #2 rst = 1'b1;
    #1;
    check("mrd_async_oe_n", int'(oe_n[0]), 1);
    pulses = 0;
    repeat (2) begin @(posedge clk); #1; if (resp_valid[0]) pulses++; end
    rst = 1'b0;
    repeat (4) begin @(posedge clk); #1; if (resp_valid[0]) pulses++; end
    check("mrd_no_resp", pulses, 0);

    // Slow-timing instance: READ_CYCLES=3, WE_CYCLES=2.
    do_op(1, 1'b1, 10'h123, 8'h3C, rd, lat, busy, we_low, oe_bad, stuck);
    check("s_we_low_cycles", we_low, 2);
    check("s_wr_busy", busy, 4);
    check("s_wr_oe_n", oe_bad, 0);
    do_op(1, 1'b0, 10'h123, 8'h00, rd, lat, busy, we_low, oe_bad, stuck);
    check("s_rdata", int'(rd), 8'h3C);
    check("s_rd_latency", lat, 4);
    check("s_rd_busy", busy, 3);
    check("s_resp_one_cycle", stuck, 0);

    check("oe_we_overlap", ovl_viol, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
